comp_sort_ctrl: RTL

- Sequencing controller that owns one shared comp_N_bit comparator instance and uses it to sort a small buffer of N-bit unsigned words into ascending order.
- Accepts a burst of 1..DEPTH words on a valid/ready input stream and bubble-sorts them in place, one comparison per cycle.
- Streams the sorted burst out on a valid/ready output stream.
- Front-end sorter for downstream min/max and threshold logic.

---
 rtl/comp_sort_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/comp_sort_ctrl.sv
// ============================================================================
//  Module   : comp_sort_ctrl (with helper comp_N_bit)
//  Purpose  : Accepts a burst of 1..DEPTH unsigned N-bit words on a
//             valid/ready stream and bubble-sorts them in place with a single
//             shared magnitude comparator, one compare per cycle. The sorted
//             burst is then streamed out in ascending order.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             in_valid/in_data/in_last/in_ready     - input burst stream
//             out_valid/out_data/out_last/out_ready - sorted output stream
//             busy                  - high while sorting or streaming out
//             count                 - words held in the current burst
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
//  comp_N_bit : unsigned magnitude comparator, one-hot G/L/E outputs
//  Ports      : a, b - operands; G = a>b, L = a<b, E = a==b
// ----------------------------------------------------------------------------
module comp_N_bit #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         G,
  output logic         L,
  output logic         E
);
  assign G = (a > b);
  assign L = (a < b);
  assign E = (a == b);
endmodule

module comp_sort_ctrl #(
  parameter int N     = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  output logic [N-1:0]  out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          busy,
  output logic [AW:0]   count
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_LOAD = 2'd1;
  localparam logic [1:0] c_SORT = 2'd2;
  localparam logic [1:0] c_OUT  = 2'd3;

  localparam logic [AW:0] c_FULL_M1 = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] c_ONE     = (AW+1)'(1);
  localparam logic [AW:0] c_TWO     = (AW+1)'(2);

  logic [1:0]    r_state;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_j;        // bubble pair index (compares j and j+1)
  logic [AW-1:0] r_k;        // output read index
  logic          r_swapped;  // any swap seen earlier in the current pass
  logic [N-1:0]  r_mem [DEPTH];

  logic [AW-1:0] w_j1;
  logic          w_accept;
  logic          w_load_end;
  logic          w_last_pair;
  logic          w_k_last;
  logic          w_gt;
  logic          w_lt;
  logic          w_eq;
  logic          w_swap;

  assign w_j1 = r_j + AW'(1);

  comp_N_bit #(.N(N)) u_cmp (
    .a (r_mem[r_j]),
    .b (r_mem[w_j1]),
    .G (w_gt),
    .L (w_lt),
    .E (w_eq)
  );

  // Swap only on strictly greater; equal entries keep their order.
  assign w_swap = w_gt && !w_lt && !w_eq;

  assign in_ready  = (r_state == c_IDLE) || (r_state == c_LOAD);
  assign out_valid = (r_state == c_OUT);
  assign busy      = (r_state == c_SORT) || (r_state == c_OUT);
  assign count     = r_count;
  assign out_data  = r_mem[r_k];

  assign w_accept    = in_valid && in_ready;
  // A full buffer ends the load regardless of in_last.
  assign w_load_end  = in_last || (r_count == c_FULL_M1);
  assign w_last_pair = ({1'b0, r_j} == (r_count - c_TWO));
  assign w_k_last    = ({1'b0, r_k} == (r_count - c_ONE));
  assign out_last    = out_valid && w_k_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_count   <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_swapped <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE, c_LOAD: begin
          if (w_accept) begin
            r_count <= r_count + c_ONE;
            if (w_load_end) begin
              if (r_count == '0) begin
                // A single word is trivially sorted.
                r_state <= c_OUT;
                r_k     <= '0;
              end else begin
                r_state   <= c_SORT;
                r_j       <= '0;
                r_swapped <= 1'b0;
              end
            end else begin
              r_state <= c_LOAD;
            end
          end
        end
        c_SORT: begin
          if (w_last_pair) begin
            // The current compare counts toward this pass's swap history.
            if (r_swapped || w_swap) begin
              r_j       <= '0;
              r_swapped <= 1'b0;
            end else begin
              r_state <= c_OUT;
              r_k     <= '0;
            end
          end else begin
            r_j       <= w_j1;
            r_swapped <= r_swapped || w_swap;
          end
        end
        c_OUT: begin
          if (out_ready) begin
            if (w_k_last) begin
              r_state <= c_IDLE;
              r_count <= '0;
              r_k     <= '0;
            end else begin
              r_k <= r_k + AW'(1);
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Buffer storage has no reset; contents are don't-care between bursts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_accept) begin
        r_mem[r_count[AW-1:0]] <= in_data;
      end else if ((r_state == c_SORT) && w_swap) begin
        r_mem[r_j]  <= r_mem[w_j1];
        r_mem[w_j1] <= r_mem[r_j];
      end
    end
  end

endmodule

`default_nettype wire
